// File: rtl/icache_pkg.sv
// icache_pkg: shared types and constants for the direct-mapped instruction cache.
//   state_e       refill FSM states (IDLE, REFILL, DONE)
//   NOP_INSTR     instruction returned on any non-hit cycle (addi x0,x0,0)
//   LINE_WORDS_C  32-bit words per line
//   OFFSET_W      word-offset / beat-counter width
//   LINE_LSB      lowest pc bit above the line offset (index starts here)
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_DONE
  } state_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam int unsigned LINE_WORDS_C = 4;
  localparam int unsigned OFFSET_W     = $clog2(LINE_WORDS_C);
  localparam int unsigned LINE_LSB     = OFFSET_W + 2;

endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-side and backing-memory-side signals of the instruction cache.
//   pc, req, flush          fetch address, request valid, invalidate-all (fence.i)
//   instr_f, stall_f        instruction to the fetch register, hold PC/fetch register
//   mem_req, mem_addr       refill request and word address of the current beat
//   mem_rvalid, mem_rdata   refill beat valid and data from backing memory
//   hit_count, miss_count   statistics, present only when ICACHE_STATS_EN is defined
// Modports: slave = cache side, master = fetch pipe + backing memory side.
interface icache_if;

  logic [31:0] pc;
  logic        req;
  logic        flush;
  logic [31:0] instr_f;
  logic        stall_f;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  pc, req, flush, mem_rvalid, mem_rdata,
    output instr_f, stall_f, mem_req, mem_addr, hit_count, miss_count
  );
  modport master (
    output pc, req, flush, mem_rvalid, mem_rdata,
    input  instr_f, stall_f, mem_req, mem_addr, hit_count, miss_count
  );
`else
  modport slave (
    input  pc, req, flush, mem_rvalid, mem_rdata,
    output instr_f, stall_f, mem_req, mem_addr
  );
  modport master (
    output pc, req, flush, mem_rvalid, mem_rdata,
    input  instr_f, stall_f, mem_req, mem_addr
  );
`endif

endinterface

// File: rtl/icache_line_array.sv
// icache_line_array: tag, valid and data storage of the direct-mapped cache.
//   clk_i, rst_i         clock, synchronous active-high reset (clears valid only)
//   flush_i              clear every valid bit this cycle
//   rd_idx_i, rd_off_i   combinational read port: line index and word offset
//   rd_tag_o, rd_valid_o, rd_word_o   read port results
//   wr_word_en_i, wr_idx_i, wr_off_i, wr_word_i   single word-write port
//   wr_tag_en_i, wr_tag_i, wr_valid_i              tag/valid write for wr_idx_i
module icache_line_array
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned IDX_W      = $clog2(NUM_LINES),
  parameter int unsigned TAG_W      = 32 - LINE_LSB - IDX_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  input  logic [OFFSET_W-1:0] rd_off_i,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic                rd_valid_o,
  output logic [31:0]         rd_word_o,
  input  logic                wr_word_en_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [OFFSET_W-1:0] wr_off_i,
  input  logic [31:0]         wr_word_i,
  input  logic                wr_tag_en_i,
  input  logic [TAG_W-1:0]    wr_tag_i,
  input  logic                wr_valid_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES*LINE_WORDS];

  // A flush arriving with the tag write must leave that line invalid too.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      if (flush_i) begin
        valid_q <= '0;
      end
      if (wr_tag_en_i) begin
        valid_q[wr_idx_i] <= wr_valid_i & ~flush_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_tag_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
    if (wr_word_en_i) begin
      data_q[{wr_idx_i, wr_off_i}] <= wr_word_i;
    end
  end

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_word_o  = data_q[{rd_idx_i, rd_off_i}];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache with 0-cycle hits and a 4-beat refill.
//   clk   single clock, rising edge
//   rst   synchronous active-high reset
//   bus   icache_if.slave: pc/req/flush in, instr_f/stall_f out,
//         mem_req/mem_addr out, mem_rvalid/mem_rdata in
// Optional: define ICACHE_STATS_EN to add the hit_count/miss_count counters
// (wrapping, 32 bits) on the interface.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input logic     clk,
  input logic     rst,
  icache_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 32 - LINE_LSB - IDX_W;

  state_e                state_q;
  logic [31-LINE_LSB:0]  base_q;
  logic [OFFSET_W-1:0]   cnt_q;
  logic                  flush_pend_q;
  logic                  mem_req_q;

  logic [OFFSET_W-1:0]   pc_off;
  logic [IDX_W-1:0]      pc_idx;
  logic [TAG_W-1:0]      pc_tag;
  logic [TAG_W-1:0]      rd_tag;
  logic                  rd_valid;
  logic [31:0]           rd_word;
  logic                  hit;
  logic                  start_refill;
  logic                  beat;
  logic                  last_beat;
  logic                  unused_pc;

  assign pc_off    = bus.pc[LINE_LSB-1:2];
  assign pc_idx    = bus.pc[LINE_LSB+IDX_W-1:LINE_LSB];
  assign pc_tag    = bus.pc[31:LINE_LSB+IDX_W];
  assign unused_pc = ^bus.pc[1:0];

  icache_line_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (bus.flush),
    .rd_idx_i     (pc_idx),
    .rd_off_i     (pc_off),
    .rd_tag_o     (rd_tag),
    .rd_valid_o   (rd_valid),
    .rd_word_o    (rd_word),
    .wr_word_en_i (beat),
    .wr_idx_i     (base_q[IDX_W-1:0]),
    .wr_off_i     (cnt_q),
    .wr_word_i    (bus.mem_rdata),
    .wr_tag_en_i  (last_beat),
    .wr_tag_i     (base_q[31-LINE_LSB:IDX_W]),
    .wr_valid_i   (~flush_pend_q)
  );

  assign hit          = bus.req && (state_q == ST_IDLE) && rd_valid && (rd_tag == pc_tag);
  assign start_refill = bus.req && (state_q == ST_IDLE) && !hit && !bus.flush;
  assign beat         = (state_q == ST_REFILL) && bus.mem_rvalid;
  assign last_beat    = beat && (cnt_q == '1);

  assign bus.instr_f  = hit ? rd_word : NOP_INSTR;
  assign bus.stall_f  = (bus.req && !hit) || (state_q != ST_IDLE);
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = {base_q, cnt_q, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_refill) begin
            state_q      <= ST_REFILL;
            base_q       <= bus.pc[31:LINE_LSB];
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            mem_req_q    <= 1'b1;
          end
        end
        ST_REFILL: begin
          // A flush mid-refill lets the refill finish but keeps the line invalid.
          if (bus.flush) begin
            flush_pend_q <= 1'b1;
          end
          if (bus.mem_rvalid) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) begin
              state_q   <= ST_DONE;
              mem_req_q <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (start_refill) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter NUM_LINES, default 16, number of direct-mapped lines; power of two, 4..256.
REQ-002 Parameter LINE_WORDS, default 4, 32-bit words per line; fixed at 4 in this revision.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 pc  input  32  fetch address from the PC register.
REQ-006 req  input  1  fetch request valid.
REQ-007 flush  input  1  invalidate the whole cache (fence.i).
REQ-008 instr_f  output  32  instruction to the fetch pipe register.
REQ-009 stall_f  output  1  high = PC and fetch pipe register shall hold.
REQ-010 mem_req  output  1  refill request to backing memory.
REQ-011 mem_addr  output  32  word address of the current refill beat.
REQ-012 mem_rvalid  input  1  backing memory beat valid.
REQ-013 mem_rdata  input  32  backing memory beat data.

Function
REQ-014 Address split SHALL be: pc[1:0] ignored, offset pc[3:2], index pc[3+log2(NUM_LINES):4], tag = remaining upper bits.
REQ-015 Hit SHALL be combinational: req & state==IDLE & valid[index] & tag match; on hit, instr_f = stored word in the same cycle (0-cycle latency) and stall_f=0.
REQ-016 When not hit, instr_f SHALL be 32'h00000013 (NOP).
REQ-017 stall_f SHALL be (req & ~hit) | (state!=IDLE).
REQ-018 FSM states SHALL be IDLE, REFILL, DONE.
REQ-019 IDLE->REFILL on req & miss & ~flush; the line base address pc[31:4] SHALL be latched; pc SHALL be ignored until DONE.
REQ-020 In REFILL, mem_req=1 and mem_addr = {latched base, beat counter, 2'b00}; each mem_rvalid SHALL write mem_rdata into word[counter] and increment the 2-bit counter.
REQ-021 On the beat with counter==3, the FSM SHALL go to DONE and write the tag; valid SHALL be set only if no flush occurred since refill start.
REQ-022 DONE SHALL last exactly one cycle with mem_req=0, then return to IDLE; the re-presented pc hits on the following cycle (miss penalty = 4 beats + 2 cycles minimum).
REQ-023 flush SHALL clear every valid bit in one cycle, in any state; flush with a hit in the same cycle SHALL still return the hit data that cycle.
REQ-024 flush during REFILL SHALL NOT abort the refill; the completed line SHALL remain invalid; flush coincident with the last beat SHALL likewise leave the line invalid.
REQ-025 mem_rvalid outside REFILL SHALL be ignored.

Reset
REQ-026 On rst: state=IDLE, all valid=0, beat counter=0, flush-pending flag=0, mem_req=0, mem_addr=0, stats counters=0.
REQ-027 rst mid-REFILL SHALL abandon the refill without setting valid; data and tag arrays need no reset.

Configuration
REQ-028 With ICACHE_STATS_EN defined, the cache SHALL add outputs hit_count and miss_count (32 bits each, wrapping), incremented once per hit cycle and once per IDLE->REFILL transition; without it, these ports and counters SHALL NOT exist.

Structure
REQ-029 Package icache_pkg SHALL hold the FSM state enum, NOP constant, and LINE_WORDS/offset-width constants.
REQ-030 Sub-module icache_line_array SHALL hold the tag, valid, and data storage with one read port and one word-write port; the FSM stays in icache.

Verification
REQ-031 Reset, then req=1, pc=0x00000000 -> stall_f=1, mem_addr sequence 0x0,0x4,0x8,0xC; after the beats and DONE, instr_f = memory word at 0x0, stall_f=0.
REQ-032 After REQ-031, pc=0x4,0x8,0xC on consecutive cycles -> hits with no mem_req, with the correct words.
REQ-033 pc=0x100 (same index, different tag as 0x0, NUM_LINES=16) -> miss, refill from 0x100; a subsequent pc=0x0 misses again.
REQ-034 flush asserted on the 2nd beat of a refill for 0x40 -> refill completes, then pc=0x40 misses again.
REQ-035 mem_rvalid held low 5 cycles mid-refill -> mem_req and mem_addr stay stable, and stall_f stays 1.
REQ-036 With ICACHE_STATS_EN: 1 miss followed by 3 hits -> miss_count=1, hit_count=3.
